// File: rtl/sub_pkg.sv
// Shared types and constants for the serial subtractor:
// FSM state encoding, condition-code bit positions and default geometry.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;
  localparam int CC_W  = 3;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_DIGIT = 8;

endpackage

// File: rtl/sub_slice.sv
// DIGIT-bit borrow-ripple subtract slice: diff = x - y - bin, bout = borrow out.
// Purely combinational; the top reuses one instance for every digit.
module sub_slice #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout
);

  // bit-serial borrow ripple across the slice
  always_comb begin
    logic w_b;
    w_b  = bin;
    diff = '0;
    for (int i = 0; i < DIGIT; i++) begin
      diff[i] = x[i] ^ y[i] ^ w_b;
      w_b     = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_b);
    end
    bout = w_b;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor d = a - b, DIGIT bits per cycle, valid/ready on both sides.
// Define SUB_FLAGS_EN to build the ZF/SF/OF condition-code logic; otherwise those outputs are 0.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
    $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_d_sh;
  logic             r_bw;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_d;
  logic             r_borrow;

  logic [DIGIT-1:0]       w_diff;
  logic                   w_bout;
  logic                   w_last;
  logic                   w_accept;
  logic                   w_finish;
  logic [WIDTH+DIGIT-1:0] w_a_cat;
  logic [WIDTH+DIGIT-1:0] w_b_cat;
  logic [WIDTH+DIGIT-1:0] w_d_cat;
  logic [WIDTH-1:0]       w_d_next;

  sub_slice #(.DIGIT(DIGIT)) u_slice (
    .x    (r_a_sh[DIGIT-1:0]),
    .y    (r_b_sh[DIGIT-1:0]),
    .bin  (r_bw),
    .diff (w_diff),
    .bout (w_bout)
  );

  // Concatenate-then-slice keeps the shifts legal even when DIGIT == WIDTH.
  assign w_a_cat  = {{DIGIT{1'b0}}, r_a_sh};
  assign w_b_cat  = {{DIGIT{1'b0}}, r_b_sh};
  assign w_d_cat  = {w_diff, r_d_sh};
  assign w_d_next = w_d_cat[WIDTH+DIGIT-1:DIGIT];
  assign w_last   = (r_cnt == CNT_LAST);
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_finish = (r_state == RUN) && w_last;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) w_next = RUN;
        else          w_next = IDLE;
      end
      RUN: begin
        if (w_last) w_next = DONE;
        else        w_next = RUN;
      end
      DONE: begin
        if (out_ready) w_next = IDLE;
        else           w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  // operand shift registers, digit accumulator, running borrow and digit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_d_sh <= '0;
      r_bw   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_d_sh <= '0;
      r_bw   <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == RUN) begin
      r_a_sh <= w_a_cat[WIDTH+DIGIT-1:DIGIT];
      r_b_sh <= w_b_cat[WIDTH+DIGIT-1:DIGIT];
      r_d_sh <= w_d_next;
      r_bw   <= w_bout;
      r_cnt  <= r_cnt + CNT_W'(1);
    end else begin
      r_a_sh <= r_a_sh;
      r_b_sh <= r_b_sh;
      r_d_sh <= r_d_sh;
      r_bw   <= r_bw;
      r_cnt  <= r_cnt;
    end
  end

  // handshake and result output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_d         <= '0;
      r_borrow    <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == IDLE);
      r_out_valid <= (w_next == DONE);
      if (w_finish) begin
        r_d      <= w_d_next;
        r_borrow <= w_bout;
      end else begin
        r_d      <= r_d;
        r_borrow <= r_borrow;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign d         = r_d;
  assign borrow    = r_borrow;

`ifdef SUB_FLAGS_EN
  logic            r_a_msb;
  logic            r_b_msb;
  logic [CC_W-1:0] r_cc;

  // operand sign capture at accept and condition codes on entry to DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cc    <= '0;
    end else if (w_accept) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
      r_cc    <= r_cc;
    end else if (w_finish) begin
      r_a_msb     <= r_a_msb;
      r_b_msb     <= r_b_msb;
      r_cc[CC_ZF] <= (w_d_next == '0);
      r_cc[CC_SF] <= w_d_next[WIDTH-1];
      r_cc[CC_OF] <= (r_a_msb != r_b_msb) && (w_d_next[WIDTH-1] != r_a_msb);
    end else begin
      r_a_msb <= r_a_msb;
      r_b_msb <= r_b_msb;
      r_cc    <= r_cc;
    end
  end

  assign zf = r_cc[CC_ZF];
  assign sf = r_cc[CC_SF];
  assign of = r_cc[CC_OF];
`else
  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: three instances at DIGIT = 8, 1 and 64 sharing clock and reset.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_v  [3];
  logic        in_ready_v  [3];
  logic        out_valid_v [3];
  logic        out_ready_v [3];
  logic [63:0] a_v         [3];
  logic [63:0] b_v         [3];
  logic [63:0] d_v         [3];
  logic        borrow_v    [3];
  logic        zf_v        [3];
  logic        sf_v        [3];
  logic        of_v        [3];

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SUB_FLAGS_EN
  localparam logic FLAGS_ON = 1'b1;
`else
  localparam logic FLAGS_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(64), .DIGIT(8)) u_d8 (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .d(d_v[0]), .borrow(borrow_v[0]), .zf(zf_v[0]), .sf(sf_v[0]), .of(of_v[0])
  );

  serial_subtractor #(.WIDTH(64), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .d(d_v[1]), .borrow(borrow_v[1]), .zf(zf_v[1]), .sf(sf_v[1]), .of(of_v[1])
  );

  serial_subtractor #(.WIDTH(64), .DIGIT(64)) u_d64 (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2]), .b(b_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .d(d_v[2]), .borrow(borrow_v[2]), .zf(zf_v[2]), .sf(sf_v[2]), .of(of_v[2])
  );

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (in_ready_v[k] !== 1'b1 || out_valid_v[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hs[%0d]: got in_ready=%b out_valid=%b, want 1/0", k, in_ready_v[k], out_valid_v[k]);
      end
      n_tests++;
      if (d_v[k] !== 64'd0 || borrow_v[k] !== 1'b0 || {zf_v[k], sf_v[k], of_v[k]} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_out[%0d]: got d=%h borrow=%b zso=%b%b%b, want all 0",
                 k, d_v[k], borrow_v[k], zf_v[k], sf_v[k], of_v[k]);
      end
    end
  endtask

  // Full transaction on instance k: accept, measure latency, check result, release with out_ready.
  task automatic do_op(input int k, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_d, input logic exp_bw, input logic exp_zf,
                       input logic exp_sf, input logic exp_of, input int exp_lat, input string nm);
    int   lat;
    logic ezf, esf, eof;
    ezf = exp_zf & FLAGS_ON;
    esf = exp_sf & FLAGS_ON;
    eof = exp_of & FLAGS_ON;
    n_tests++;
    if (in_ready_v[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s[%0d] in_ready before accept: got %b want 1", nm, k, in_ready_v[k]);
    end
    a_v[k]        = a;
    b_v[k]        = b;
    in_valid_v[k] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
    a_v[k]        = 64'hDEAD_BEEF_CAFE_F00D;
    b_v[k]        = 64'h0123_4567_89AB_CDEF;
    n_tests++;
    if (in_ready_v[k] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s[%0d] in_ready after accept: got %b want 0", nm, k, in_ready_v[k]);
    end
    lat = 0;
    while (out_valid_v[k] !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s[%0d] latency: got %0d want %0d", nm, k, lat, exp_lat);
    end
    n_tests++;
    if (d_v[k] !== exp_d) begin
      n_fail++;
      $display("FAIL %s[%0d] d: got %h want %h", nm, k, d_v[k], exp_d);
    end
    n_tests++;
    if (borrow_v[k] !== exp_bw) begin
      n_fail++;
      $display("FAIL %s[%0d] borrow: got %b want %b", nm, k, borrow_v[k], exp_bw);
    end
    n_tests++;
    if ({zf_v[k], sf_v[k], of_v[k]} !== {ezf, esf, eof}) begin
      n_fail++;
      $display("FAIL %s[%0d] flags zso: got %b%b%b want %b%b%b", nm, k,
               zf_v[k], sf_v[k], of_v[k], ezf, esf, eof);
    end
    out_ready_v[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[k] = 1'b0;
    n_tests++;
    if (out_valid_v[k] !== 1'b0 || in_ready_v[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s[%0d] release: got out_valid=%b in_ready=%b want 0/1", nm, k,
               out_valid_v[k], in_ready_v[k]);
    end
  endtask

  task automatic test_vectors(input int k, input int lat);
    do_op(k, 64'd10, 64'd3, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0, lat, "10m3");
    do_op(k, 64'd3, 64'd10, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0, 1'b1, 1'b0, lat, "3m10");
    do_op(k, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF,
          1'b0, 1'b0, 1'b0, 1'b1, lat, "minm1");
    do_op(k, 64'h1234, 64'h1234, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat, "eq");
    do_op(k, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
          1'b1, 1'b0, 1'b1, 1'b1, lat, "maxmneg1");
  endtask

  task automatic test_backpressure();
    int lat;
    a_v[0]        = 64'd100;
    b_v[0]        = 64'd1;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    // keep in_valid high with new operands: ignored while busy
    a_v[0] = 64'd7;
    b_v[0] = 64'd2;
    lat = 0;
    while (out_valid_v[0] !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != 8) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d want 8", lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (d_v[0] !== 64'd99 || out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: got d=%h out_valid=%b in_ready=%b want 63/1/0",
                 c, d_v[0], out_valid_v[0], in_ready_v[0]);
      end
    end
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0;
    n_tests++;
    if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || d_v[0] !== 64'd99) begin
      n_fail++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b d=%h want 1/0/63",
               in_ready_v[0], out_valid_v[0], d_v[0]);
    end
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    n_tests++;
    if (in_ready_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: got in_ready=%b want 0", in_ready_v[0]);
    end
    lat = 0;
    while (out_valid_v[0] !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != 8 || d_v[0] !== 64'd5 || borrow_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second: got lat=%0d d=%h borrow=%b want 8/5/0", lat, d_v[0], borrow_v[0]);
    end
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    a_v[0]        = 64'd10;
    b_v[0]        = 64'd3;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++;
    if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || d_v[0] !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got in_ready=%b out_valid=%b d=%h want 1/0/0",
               in_ready_v[0], out_valid_v[0], d_v[0]);
    end
    repeat (10) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_discard: got out_valid=%b in_ready=%b want 0/1", out_valid_v[0], in_ready_v[0]);
    end
    do_op(0, 64'd5, 64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8, "rst_5m5");
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid_v[k]  = 1'b0;
      out_ready_v[k] = 1'b0;
      a_v[k]         = 64'd0;
      b_v[k]         = 64'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_vectors(0, 8);
    test_vectors(1, 64);
    test_vectors(2, 1);
    test_backpressure();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
